product_accumulator: RTL
========================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter COUNT_N, default 4: products summed per batch; legal range 1..255.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 20: accumulator and result width; legal range 17..32.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port inProduct  input  16  unsigned product from the upstream shift-add multiplier.
REQ-006 The block SHALL have port inValid  input  1  inProduct holds a finished product.
REQ-007 The block SHALL have port inReady  output  1  block accepts a product this cycle.
REQ-008 The block SHALL have port clear  input  1  synchronous abort of the current batch.
REQ-009 The block SHALL have port outSum  output  ACC_WIDTH  batch sum.
REQ-010 The block SHALL have port outValid  output  1  outSum holds a completed batch.
REQ-011 The block SHALL have port outReady  input  1  downstream consumes outSum.
REQ-012 The block SHALL have port overflow  output  1  sticky per batch: the sum exceeded 2^ACC_WIDTH-1.

Function
REQ-013 The block SHALL implement a two-state FSM, ACCUM and HOLD, with ACCUM as the reset state.
REQ-014 In ACCUM: inReady=1, outValid=0.
REQ-015 In ACCUM, an accept (inValid&inReady) SHALL add zero-extended inProduct to the accumulator and increment a batch counter of width clog2(COUNT_N+1).
REQ-016 An accept that brings the counter to COUNT_N SHALL move the FSM to HOLD at the next edge; outSum and outValid are valid 1 cycle after the last accept.
REQ-017 In HOLD: inReady=0, outValid=1; outSum and overflow SHALL stay stable until the handshake completes.
REQ-018 In HOLD, outValid&outReady SHALL zero the accumulator, counter and overflow and return the FSM to ACCUM at the next edge, with no product accepted in that cycle.
REQ-019 inValid without inReady SHALL have no effect; the upstream holds inProduct until it is accepted.
REQ-020 When an addition carries out of ACC_WIDTH bits, overflow SHALL be set and remain set until the batch is consumed, cleared or reset.
REQ-021 clear=1 SHALL zero the accumulator, counter and overflow and force ACCUM at the next edge, in either state; clear has priority over accept and over the output handshake.
REQ-022 Simultaneous clear and an accept SHALL discard the product.
REQ-023 With COUNT_N=1, every accept SHALL go directly to HOLD.
REQ-024 outSum SHALL drive the accumulator register directly, with no combinational path from inputs to outSum.

Reset
REQ-025 rst=0 at a rising edge SHALL force ACCUM, accumulator=0, counter=0, overflow=0, outValid=0, inReady=1 at the next cycle; reset has priority over clear and all handshakes.
REQ-026 Reset asserted mid-batch or in HOLD SHALL discard the partial or pending sum, with no outValid pulse after release.

Configuration
REQ-027 Macro PRODUCT_ACCUMULATOR_SATURATE_EN defined: on carry-out, the accumulator SHALL clamp to 2^ACC_WIDTH-1 and stay there for the rest of the batch.
REQ-028 Macro PRODUCT_ACCUMULATOR_SATURATE_EN undefined: the accumulator SHALL wrap modulo 2^ACC_WIDTH.
REQ-029 overflow SHALL behave identically with and without PRODUCT_ACCUMULATOR_SATURATE_EN.

Verification
REQ-030 Basic batch (COUNT_N=4, ACC_WIDTH=20): products 10, 20, 30, 40 on consecutive cycles -> outSum=100, outValid=1 one cycle after the 4th accept, overflow=0.
REQ-031 Backpressure: outReady=0 for 5 cycles after the basic batch -> outValid=1, outSum=100 and inReady=0 are held; outReady=1 -> ACCUM next cycle and accumulator=0.
REQ-032 Overflow (ACC_WIDTH=17): four products of 0xFFFF -> overflow=1; outSum=0x1FFFC without the macro, outSum=0x1FFFF with PRODUCT_ACCUMULATOR_SATURATE_EN.
REQ-033 Clear mid-batch: 2 products of 5, then clear together with a product of 7, then 4 products of 1 -> outSum=4.
REQ-034 Reset in HOLD: rst=0 for 1 cycle while outValid=1 -> outValid=0, inReady=1, outSum=0 next cycle; the next batch sums from zero.
REQ-035 Gapped input: inValid toggling every other cycle with products 1, 2, 3, 4 -> exactly 4 accepts and outSum=10.

Source files
------------

// File: rtl/product_accumulator.sv
// Batch accumulator: sums COUNT_N unsigned 16-bit products, then holds the sum until consumed.
// Optional PRODUCT_ACCUMULATOR_SATURATE_EN clamps the sum at all-ones on carry-out instead of wrapping.
//
// state | meaning
// ACCUM | accepting products, inReady=1, outValid=0
// HOLD  | batch complete, outSum/overflow frozen until outValid&outReady
module product_accumulator #(
    parameter int COUNT_N   = 4,
    parameter int ACC_WIDTH = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          inProduct,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] outSum,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 overflow
);

    localparam int               CNT_W = $clog2(COUNT_N + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT_N);

    typedef enum logic {ACCUM, HOLD} stateT;

    stateT                state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     count;
    logic [ACC_WIDTH:0]   sumExt;
    logic [ACC_WIDTH-1:0] nextAcc;
    logic                 accept;

    assign accept = inValid & inReady;
    assign sumExt = {1'b0, acc} + {{(ACC_WIDTH - 15){1'b0}}, inProduct};

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once clamped, the sum stays pinned for the rest of the batch.
    assign nextAcc = (sumExt[ACC_WIDTH] || overflow) ? '1 : sumExt[ACC_WIDTH-1:0];
`else
    assign nextAcc = sumExt[ACC_WIDTH-1:0];
`endif

    assign outSum = acc;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc      <= nextAcc;
                        overflow <= overflow | sumExt[ACC_WIDTH];
                        count    <= count + CNT_W'(1);
                        if (count == LAST - CNT_W'(1)) begin
                            state    <= HOLD;
                            inReady  <= 1'b0;
                            outValid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (outReady) begin
                        state    <= ACCUM;
                        acc      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        inReady  <= 1'b1;
                        outValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= ACCUM;
                    inReady  <= 1'b1;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
